im_fetch_ctrl: RTL and testbench
================================

IM_FETCH_CTRL -- requirements
Module: im_fetch_ctrl

Interface
REQ-001 Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction word that stops sequential fetch.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Start  input  1  one-cycle pulse; (re)start fetch at StartAddr.
REQ-005 StartAddr  input  8  word address of the first instruction.
REQ-006 Address  output  8  word address driven to the combinational IM; equals PC register.
REQ-007 InstructionIn  input  32  IM read data for Address, same cycle.
REQ-008 BranchTaken  input  1  one-cycle redirect request from decode/execute.
REQ-009 BranchTarget  input  8  redirect word address.
REQ-010 InstrValid  output  1  InstrOut/PCOut hold a valid fetched instruction.
REQ-011 InstrOut  output  32  registered fetched instruction.
REQ-012 PCOut  output  8  address InstrOut was fetched from.
REQ-013 Ready  input  1  decode accepts; transfer when InstrValid && Ready.
REQ-014 State  output  2  IDLE=0, FETCH=1, HALT=2; 3 unused.
REQ-015 FetchCount  output  16  number of accepted transfers since reset/Start, saturating.

Function
REQ-016 States: IDLE (no fetch), FETCH (sequential fetch), HALT (HALT_WORD captured, fetch stopped).
REQ-017 IDLE: Start -> FETCH, PC<=StartAddr, InstrValid<=0, FetchCount<=0; other inputs ignored.
REQ-018 FETCH, capture condition = !InstrValid || Ready: InstrOut<=InstructionIn, PCOut<=PC, InstrValid<=1, PC<=PC+1.
REQ-019 FETCH, InstrValid && !Ready: InstrOut, PCOut, InstrValid, PC all hold (stall, no IM word lost or repeated).
REQ-020 PC increment is mod 256; 8'hFF+1 wraps to 8'h00 without any flag or state change.
REQ-021 Latency: Start at edge N -> Address=StartAddr during cycle N+1 -> InstrValid=1 with IM[StartAddr] from edge N+2; one instruction per cycle thereafter while Ready=1.
REQ-022 BranchTaken in FETCH: PC<=BranchTarget, InstrValid<=0 (held instruction flushed, not counted), no capture that cycle; first target word valid two edges later.
REQ-023 Start in FETCH or HALT: same as REQ-017 (flush, PC<=StartAddr, FetchCount<=0, State<=FETCH).
REQ-024 Priority when simultaneous: Rst_n > Start > BranchTaken > capture/stall.
REQ-025 Captured word == HALT_WORD: it is presented normally (InstrValid=1), State<=HALT on same edge, PC not incremented.
REQ-026 HALT: no further capture; held word remains until transferred, then InstrValid<=0; BranchTaken ignored; only Start or reset leaves HALT.
REQ-027 FetchCount increments by 1 on each edge with InstrValid && Ready and no Start/BranchTaken that cycle; saturates at 16'hFFFF.
REQ-028 Transfer coinciding with BranchTaken is still consumed by decode but is not counted.

Reset
REQ-029 Rst_n=0 asynchronously forces State=IDLE, PC/Address=0, InstrValid=0, InstrOut=0, PCOut=0, FetchCount=0, regardless of Clk.
REQ-030 Reset asserted mid-fetch or mid-stall discards held instruction; after release block stays IDLE until Start.
REQ-031 Reset release takes effect on first rising Clk edge with Rst_n=1; Start on that same edge is honoured.

Verification
REQ-032 Start, StartAddr=0, Ready=1, IM holds i at addr i -> InstrValid from edge 2, InstrOut/PCOut = 0,1,2,3...; FetchCount tracks transfers.
REQ-033 Ready=0 for 3 cycles while InstrValid=1, PCOut=5 -> InstrOut/PCOut/Address frozen; Ready=1 -> PCOut 5 then 6, no skip or duplicate.
REQ-034 BranchTaken with BranchTarget=10 while PCOut=3 -> InstrValid=0 next cycle, then PCOut=10, 11...; flushed word not counted.
REQ-035 StartAddr=8'hFE, Ready=1 -> PCOut sequence FE, FF, 00, 01; State stays FETCH.
REQ-036 HALT_WORD at addr 5, start at 3 -> words 3,4,5 delivered, State=HALT at capture of 5, InstrValid=0 after its transfer; BranchTaken ignored; Start at 0 resumes from 0.
REQ-037 Rst_n pulsed low between edges during stall -> outputs zero immediately, State=IDLE, no fetch until Start.

Source files
------------

// File: rtl/im_fetch_ctrl.sv
// Instruction-memory fetch controller: sequential fetch from a combinational IM
// with stall, branch redirect, halt-word detection and a transfer counter.
module im_fetch_ctrl #(
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  start_addr,
  output logic [7:0]  address,
  input  logic [31:0] instruction_in,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [7:0]  pc_out,
  input  logic        ready,
  output logic [1:0]  state,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  pc_r;
  logic        instr_valid_r;
  logic [31:0] instr_out_r;
  logic [7:0]  pc_out_r;
  logic [15:0] fetch_count_r;

  logic        transfer_s;
  logic        capture_s;
  logic        halt_hit_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  assign transfer_s = instr_valid_r & ready;
  assign capture_s  = ~instr_valid_r | ready;
  assign halt_hit_s = (instruction_in == HALT_WORD);

  assign address     = pc_r;
  assign instr_valid = instr_valid_r;
  assign instr_out   = instr_out_r;
  assign pc_out      = pc_out_r;
  assign state       = state_r;
  assign fetch_count = fetch_count_r;

  // Fetch state machine, output holding register and transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= 8'd0;
      instr_valid_r <= 1'b0;
      instr_out_r   <= 32'd0;
      pc_out_r      <= 8'd0;
      fetch_count_r <= 16'd0;
    end else if (start) begin
      state_r       <= ST_FETCH;
      pc_r          <= start_addr;
      instr_valid_r <= 1'b0;
      fetch_count_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_FETCH: begin
          if (branch_taken) begin
            // Held word is flushed; a coincident transfer is not counted.
            pc_r          <= branch_target;
            instr_valid_r <= 1'b0;
          end else begin
            if (transfer_s) begin
              fetch_count_r <= sat_inc(fetch_count_r);
            end
            if (capture_s) begin
              instr_out_r   <= instruction_in;
              pc_out_r      <= pc_r;
              instr_valid_r <= 1'b1;
              if (halt_hit_s) begin
                state_r <= ST_HALT;
              end else begin
                pc_r <= pc_r + 8'd1;
              end
            end
          end
        end
        ST_HALT: begin
          // Redirects are ignored here; only the held word drains.
          if (transfer_s) begin
            instr_valid_r <= 1'b0;
            fetch_count_r <= sat_inc(fetch_count_r);
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed, table-driven bench for im_fetch_ctrl with a combinational IM model.
module tb_im_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_addr;
  logic [7:0]  address;
  logic [31:0] instruction_in;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [7:0]  pc_out;
  logic        ready;
  logic [1:0]  state;
  logic [15:0] fetch_count;

  logic [31:0] im [256];
  assign instruction_in = im[address];

  int nvec = 0;
  int nbad = 0;

  im_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .address(address), .instruction_in(instruction_in),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
    .ready(ready), .state(state), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [7:0]  sa;
    logic        br;
    logic [7:0]  bt;
    logic        rdy;
    logic [1:0]  e_state;
    logic        e_valid;
    logic [7:0]  e_pco;
    logic [31:0] e_ins;
    logic [7:0]  e_addr;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, input logic [7:0] sa, input logic br,
                              input logic [7:0] bt, input logic rdy, input logic [1:0] es,
                              input logic ev, input logic [7:0] ep, input logic [31:0] ei,
                              input logic [7:0] ea, input logic [15:0] ec);
    vec_t v;
    v.st = st; v.sa = sa; v.br = br; v.bt = bt; v.rdy = rdy;
    v.e_state = es; v.e_valid = ev; v.e_pco = ep; v.e_ins = ei; v.e_addr = ea; v.e_cnt = ec;
    return v;
  endfunction

  task automatic drive(input logic st, input logic [7:0] sa, input logic br,
                       input logic [7:0] bt, input logic rdy);
    start = st; start_addr = sa; branch_taken = br; branch_target = bt; ready = rdy;
  endtask

  task automatic check(input string name, input logic [1:0] es, input logic ev,
                       input logic [7:0] ep, input logic [31:0] ei, input logic [7:0] ea,
                       input logic [15:0] ec);
    nvec++;
    if (state !== es || instr_valid !== ev || pc_out !== ep || instr_out !== ei ||
        address !== ea || fetch_count !== ec) begin
      nbad++;
      $display("FAIL %s: got state=%0d valid=%0b pc_out=%h instr=%h addr=%h cnt=%0d, want state=%0d valid=%0b pc_out=%h instr=%h addr=%h cnt=%0d",
               name, state, instr_valid, pc_out, instr_out, address, fetch_count,
               es, ev, ep, ei, ea, ec);
    end
  endtask

  // Apply inputs after an edge, clock once, sample 1 time unit after the edge.
  task automatic step(input logic st, input logic [7:0] sa, input logic br,
                      input logic [7:0] bt, input logic rdy);
    drive(st, sa, br, bt, rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) im[i] = 32'(i);
    rst_n = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset", 2'd0, 1'b0, 8'h00, 32'd0, 8'h00, 16'd0);
    rst_n = 1'b1;
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    check("idle_no_start", 2'd0, 1'b0, 8'h00, 32'd0, 8'h00, 16'd0);

    // Sequential fetch, stall at pc_out 5, start at FE (wrap), branch at pc_out 3, priority.
    vecs[0]  = mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b0, 8'h00, 32'd0,  8'h00, 16'd0);
    vecs[1]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h00, 32'd0,  8'h01, 16'd0);
    vecs[2]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h01, 32'd1,  8'h02, 16'd1);
    vecs[3]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h02, 32'd2,  8'h03, 16'd2);
    vecs[4]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h03, 32'd3,  8'h04, 16'd3);
    vecs[5]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h04, 32'd4,  8'h05, 16'd4);
    vecs[6]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h05, 32'd5,  8'h06, 16'd5);
    vecs[7]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 8'h05, 32'd5,  8'h06, 16'd5);
    vecs[8]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 8'h05, 32'd5,  8'h06, 16'd5);
    vecs[9]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 8'h05, 32'd5,  8'h06, 16'd5);
    vecs[10] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h06, 32'd6,  8'h07, 16'd6);
    vecs[11] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h07, 32'd7,  8'h08, 16'd7);
    vecs[12] = mk(1'b1, 8'hFE, 1'b0, 8'h00, 1'b1, 2'd1, 1'b0, 8'h07, 32'd7,  8'hFE, 16'd0);
    vecs[13] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'hFE, 32'hFE, 8'hFF, 16'd0);
    vecs[14] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'hFF, 32'hFF, 8'h00, 16'd1);
    vecs[15] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h00, 32'd0,  8'h01, 16'd2);
    vecs[16] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h01, 32'd1,  8'h02, 16'd3);
    vecs[17] = mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b0, 8'h01, 32'd1,  8'h00, 16'd0);
    vecs[18] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h00, 32'd0,  8'h01, 16'd0);
    vecs[19] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h01, 32'd1,  8'h02, 16'd1);
    vecs[20] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h02, 32'd2,  8'h03, 16'd2);
    vecs[21] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h03, 32'd3,  8'h04, 16'd3);
    vecs[22] = mk(1'b0, 8'h00, 1'b1, 8'd10,  1'b1, 2'd1, 1'b0, 8'h03, 32'd3,  8'd10,  16'd3);
    vecs[23] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'd10,  32'd10, 8'd11,  16'd3);
    vecs[24] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'd11,  32'd11, 8'd12,  16'd4);
    vecs[25] = mk(1'b1, 8'd20,  1'b1, 8'd50,  1'b1, 2'd1, 1'b0, 8'd11,  32'd11, 8'd20,  16'd0);
    vecs[26] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'd20,  32'd20, 8'd21,  16'd0);
    vecs[27] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 8'd20,  32'd20, 8'd21,  16'd0);
    vecs[28] = mk(1'b0, 8'h00, 1'b1, 8'd40,  1'b0, 2'd1, 1'b0, 8'd20,  32'd20, 8'd40,  16'd0);
    vecs[29] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'd40,  32'd40, 8'd41,  16'd0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].st, vecs[i].sa, vecs[i].br, vecs[i].bt, vecs[i].rdy);
      check($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_valid, vecs[i].e_pco,
            vecs[i].e_ins, vecs[i].e_addr, vecs[i].e_cnt);
    end

    // Halt word at address 5, fetch starting at 3.
    im[5] = 32'hFFFF_FFFF;
    step(1'b1, 8'd3, 1'b0, 8'd0, 1'b1);
    check("halt_start", 2'd1, 1'b0, 8'd40, 32'd40, 8'd3, 16'd0);
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    check("halt_w3", 2'd1, 1'b1, 8'd3, 32'd3, 8'd4, 16'd0);
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    check("halt_w4", 2'd1, 1'b1, 8'd4, 32'd4, 8'd5, 16'd1);
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    check("halt_capture", 2'd2, 1'b1, 8'd5, 32'hFFFF_FFFF, 8'd5, 16'd2);
    step(1'b0, 8'd0, 1'b1, 8'd9, 1'b0);
    check("halt_hold_br", 2'd2, 1'b1, 8'd5, 32'hFFFF_FFFF, 8'd5, 16'd2);
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    check("halt_drain", 2'd2, 1'b0, 8'd5, 32'hFFFF_FFFF, 8'd5, 16'd3);
    step(1'b0, 8'd0, 1'b1, 8'd9, 1'b1);
    check("halt_br_ign", 2'd2, 1'b0, 8'd5, 32'hFFFF_FFFF, 8'd5, 16'd3);
    step(1'b1, 8'd0, 1'b0, 8'd0, 1'b1);
    check("halt_restart", 2'd1, 1'b0, 8'd5, 32'hFFFF_FFFF, 8'd0, 16'd0);
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    check("halt_resume", 2'd1, 1'b1, 8'd0, 32'd0, 8'd1, 16'd0);
    im[5] = 32'd5;

    // Asynchronous reset in the middle of a stall.
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    check("pre_rst_stall", 2'd1, 1'b1, 8'd0, 32'd0, 8'd1, 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 2'd0, 1'b0, 8'd0, 32'd0, 8'd0, 16'd0);
    #1;
    rst_n = 1'b1;
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    check("idle_after_rst", 2'd0, 1'b0, 8'd0, 32'd0, 8'd0, 16'd0);

    // Start on the first edge after release is honoured.
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'd7, 1'b0, 8'd0, 1'b1);
    check("start_at_release", 2'd1, 1'b0, 8'd0, 32'd0, 8'd7, 16'd0);
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    check("release_first", 2'd1, 1'b1, 8'd7, 32'd7, 8'd8, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
